ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the Execute stage, downstream of the D->E pipeline register.
//  Takes data1E/data2E operands; owns the architectural HI/LO registers.
//  Serves MFHI/MFLO reads and MTHI/MTLO writes.
//  Raises StallMDE to the hazard unit while a result is pending; the hazard unit then stalls F/D and flushes E.
// PARAMETERS
//  XLEN    32  operand/result width (HI, LO each XLEN)
//  CNT_W    6  iteration counter width, must hold XLEN
// PORTS
//  clk       in   1     rising-edge clock
//  rst_n     in   1     async active-low reset
//  StartE    in   1     valid mult/div instruction in E this cycle
//  MdOpE     in   2     00 mult, 01 multu, 10 div, 11 divu
//  data1E    in   XLEN  rs operand (multiplicand / dividend)
//  data2E    in   XLEN  rt operand (multiplier / divisor)
//  MfHiE     in   1     mfhi in E
//  MfLoE     in   1     mflo in E
//  MtHiE     in   1     mthi in E (writes data1E)
//  MtLoE     in   1     mtlo in E (writes data1E)
//  MdReadE   out  XLEN  HI if MfHiE, else LO (combinational)
//  BusyE     out  1     state != IDLE
//  StallMDE  out  1     BusyE & (StartE|MfHiE|MfLoE|MtHiE|MtLoE)
//  DoneE     out  1     1-cycle pulse on the edge after HI/LO update
// BEHAVIOUR
//  - Reset (async, any state, incl. mid-op): state=IDLE, HI=LO=0, counter=0, DoneE=0, operand/accum regs=0.
//  - FSM IDLE -> RUN -> FINISH -> IDLE.
//  - IDLE, StartE=1 at edge k: latch operands and op; cnt=0; go to RUN.
//  - StartE with BusyE=1 is ignored. The hazard unit re-presents it after stall.
//  - RUN: one step per edge for XLEN edges (k+1..k+XLEN); at cnt==XLEN-1 go to FINISH.
//    - mult: shift-add on a 2*XLEN accumulator.
//    - div: restoring, one quotient bit per step.
//  - FINISH (edge k+XLEN+1): apply sign fix; write HI/LO; go to IDLE; DoneE=1 the following cycle.
//    - mult: HI = product[2X-1:X], LO = product[X-1:0].
//    - div: LO = quotient, HI = remainder.
//  - Latency: BusyE high for XLEN+1 cycles. Result visible via MdReadE from cycle k+XLEN+2.
//  - Divide by zero: HI = dividend, LO = all ones; no sign fix; no trap.
//  - MTHI/MTLO in IDLE: update HI/LO at the edge. While busy: dropped, StallMDE=1.
//  - StartE together with MtHiE/MtLoE in IDLE: Start wins, MT dropped. Decode never generates this; the bench asserts on it.
//  - MfHiE/MfLoE while busy: StallMDE=1, MdReadE holds the old HI/LO.
//  - Arithmetic is mod 2^XLEN per half; no overflow flags.
// CONFIGURATION
//  - MDU_SIGNED_EN defined:
//    - ops 00/10 are signed.
//    - Magnitudes latched at start; FINISH negates the product/quotient when operand signs differ.
//    - The remainder takes the dividend's sign.
//  - MDU_SIGNED_EN undefined:
//    - MdOpE[0] ignored; all ops unsigned.
//    - FINISH still takes one cycle, so latency is identical.
// STRUCTURE
//  - mdu_pkg: MdOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state enum (IDLE/RUN/FINISH), XLEN default.
//  - One sub-module, mdu_step: combinational single iteration. Takes {accum, operand, is_div} and returns next accum.
//  - ex_muldiv_unit keeps the FSM, counter, HI/LO and sign logic.
// TESTING
//  1. multu 0xFFFFFFFF*0xFFFFFFFF -> Busy 33 cycles; HI=0xFFFFFFFE, LO=0x00000001; DoneE one pulse.
//  2. divu 100/7 -> LO=14, HI=2.
//     div -100/7 with MDU_SIGNED_EN -> LO=0xFFFFFFF2, HI=0xFFFFFFFE.
//  3. divu 0x1234/0 -> HI=0x1234, LO=0xFFFFFFFF.
//  4. mflo at cycle k+5 of a mult -> StallMDE=1 until Busy drops; MdReadE=new LO at k+34.
//  5. mthi 0xDEAD while busy -> dropped, HI ends as mult result.
//     mthi 0xDEAD in IDLE -> HI=0xDEAD next cycle.
//  6. rst_n low at RUN cnt=10 -> BusyE=0, HI=LO=0 immediately; the next StartE is accepted normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit.
// Contents: operation encodings, FSM state type and default widths.
// Imported by mdu_step and ex_muldiv_unit.
package mdu_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   i_accum   [2*XLEN-1:0]  current accumulator {upper, lower}
//   i_operand [XLEN-1:0]    multiplicand (mult) or divisor (div)
//   i_is_div                1 = restoring divide step, 0 = shift-add multiply step
//   o_accum   [2*XLEN-1:0]  accumulator after this step
// Multiply: lower half starts as the multiplier and shifts out LSB-first
// while the product grows into the upper half from the top.
// Divide: lower half starts as the dividend; quotient bits shift in at
// the bottom while the partial remainder builds up in the upper half.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2*XLEN-1:0] i_accum,
    input  logic [XLEN-1:0]   i_operand,
    input  logic              i_is_div,
    output logic [2*XLEN-1:0] o_accum
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;

    // Single shift-add or restoring-subtract step
    always_comb begin
        w_sum    = {1'b0, i_accum[2*XLEN-1:XLEN]}
                 + (i_accum[0] ? {1'b0, i_operand} : {(XLEN+1){1'b0}});
        // Remainder shifted left with the next dividend bit; needs XLEN+1 bits.
        w_rem_sh = i_accum[2*XLEN-1:XLEN-1];
        w_diff   = w_rem_sh - {1'b0, i_operand};
        if (i_is_div) begin
            // Top bit of the difference set means the divisor did not fit.
            if (!w_diff[XLEN]) begin
                o_accum = {w_diff[XLEN-1:0], i_accum[XLEN-2:0], 1'b1};
            end else begin
                o_accum = {w_rem_sh[XLEN-1:0], i_accum[XLEN-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add lands in the top bit after the shift.
            o_accum = {w_sum, i_accum[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit in the Execute stage; owns HI/LO.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   StartE, MdOpE[1:0]      start a mult/multu/div/divu
//   data1E, data2E          rs / rt operands
//   MfHiE, MfLoE            mfhi / mflo in E
//   MtHiE, MtLoE            mthi / mtlo in E (write data1E)
//   MdReadE                 HI if MfHiE else LO (combinational)
//   BusyE                   operation in flight
//   StallMDE                busy and E needs the unit
//   DoneE                   one-cycle pulse once HI/LO hold the new result
// Build option: MDU_SIGNED_EN makes ops 00/10 signed (magnitude iteration,
// sign fix in FINISH); otherwise every op is unsigned.
module ex_muldiv_unit
    import mdu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic [1:0]      MdOpE,
    input  logic [XLEN-1:0] data1E,
    input  logic [XLEN-1:0] data2E,
    input  logic            MfHiE,
    input  logic            MfLoE,
    input  logic            MtHiE,
    input  logic            MtLoE,
    output logic [XLEN-1:0] MdReadE,
    output logic            BusyE,
    output logic            StallMDE,
    output logic            DoneE
);

    mdu_state_e        r_state;
    mdu_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_done;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_dvd;
    logic              r_is_div;
    logic              r_div0;
    logic              r_neg_res;
    logic              r_neg_rem;

    logic              w_signed;
    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [2*XLEN-1:0] w_step_acc;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res_hi;
    logic [XLEN-1:0]   w_res_lo;

`ifdef MDU_SIGNED_EN
    assign w_signed = ~MdOpE[0];
`else
    // Bit 0 has no effect in the unsigned build.
    assign w_signed = MdOpE[0] & 1'b0;
`endif

    assign w_neg1 = w_signed & data1E[XLEN-1];
    assign w_neg2 = w_signed & data2E[XLEN-1];
    assign w_mag1 = w_neg1 ? (~data1E + XLEN'(1)) : data1E;
    assign w_mag2 = w_neg2 ? (~data2E + XLEN'(1)) : data2E;

    mdu_step #(.XLEN(XLEN)) u_step (
        .i_accum   (r_acc),
        .i_operand (r_opnd),
        .i_is_div  (r_is_div),
        .o_accum   (w_step_acc)
    );

    // Result formatting with sign fix and divide-by-zero override
    always_comb begin
        w_prod = r_neg_res ? (~r_acc + (2*XLEN)'(1)) : r_acc;
        w_quo  = r_neg_res ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
        w_rem  = r_neg_rem ? (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];
        if (!r_is_div) begin
            w_res_hi = w_prod[2*XLEN-1:XLEN];
            w_res_lo = w_prod[XLEN-1:0];
        end else if (r_div0) begin
            w_res_hi = r_dvd;
            w_res_lo = {XLEN{1'b1}};
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; StartE while busy is simply not looked at
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = StartE ? RUN : IDLE;
            RUN:     w_state_nxt = (r_cnt == CNT_W'(XLEN-1)) ? FINISH : RUN;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO update, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_hi      <= {XLEN{1'b0}};
            r_lo      <= {XLEN{1'b0}};
            r_done    <= 1'b0;
            r_acc     <= {(2*XLEN){1'b0}};
            r_opnd    <= {XLEN{1'b0}};
            r_dvd     <= {XLEN{1'b0}};
            r_is_div  <= 1'b0;
            r_div0    <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            r_done <= (r_state == FINISH);
            case (r_state)
                IDLE: begin
                    if (StartE) begin
                        // Start takes priority; a simultaneous MT is dropped.
                        r_cnt     <= {CNT_W{1'b0}};
                        r_acc     <= {{XLEN{1'b0}}, w_mag1};
                        r_opnd    <= w_mag2;
                        r_dvd     <= data1E;
                        r_is_div  <= MdOpE[1];
                        r_div0    <= (data2E == {XLEN{1'b0}});
                        r_neg_res <= w_neg1 ^ w_neg2;
                        r_neg_rem <= w_neg1;
                    end else begin
                        if (MtHiE) begin
                            r_hi <= data1E;
                        end
                        if (MtLoE) begin
                            r_lo <= data1E;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FINISH: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign MdReadE  = MfHiE ? r_hi : r_lo;
    assign BusyE    = (r_state != IDLE);
    assign StallMDE = BusyE & (StartE | MfHiE | MfLoE | MtHiE | MtLoE);
    assign DoneE    = r_done;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (default 32-bit build).
module tb_ex_muldiv_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StartE;
    logic [1:0]  MdOpE;
    logic [31:0] data1E;
    logic [31:0] data2E;
    logic        MfHiE, MfLoE, MtHiE, MtLoE;
    logic [31:0] MdReadE;
    logic        BusyE, StallMDE, DoneE;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .StartE(StartE), .MdOpE(MdOpE),
        .data1E(data1E), .data2E(data2E), .MfHiE(MfHiE), .MfLoE(MfLoE),
        .MtHiE(MtHiE), .MtLoE(MtLoE), .MdReadE(MdReadE), .BusyE(BusyE),
        .StallMDE(StallMDE), .DoneE(DoneE)
    );

    always #5 clk = ~clk;

    // Decode must never issue a start together with an MT
    always @(posedge clk) begin
        if (rst_n === 1'b1 && StartE === 1'b1 && (MtHiE === 1'b1 || MtLoE === 1'b1))
            $error("start and mthi/mtlo asserted together");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        MfHiE = 1'b1;
        #1 hi = MdReadE;
        MfHiE = 1'b0;
        MfLoE = 1'b1;
        #1 lo = MdReadE;
        MfLoE = 1'b0;
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles);
        StartE = 1'b1; MdOpE = op; data1E = a; data2E = b;
        step();
        StartE = 1'b0; data1E = 32'h0; data2E = 32'h0;
        busy_cycles = 0;
        while (BusyE === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        rst_n = 1'b0; StartE = 1'b0; MdOpE = 2'b00; data1E = 32'h0; data2E = 32'h0;
        MfHiE = 1'b0; MfLoE = 1'b0; MtHiE = 1'b0; MtLoE = 1'b0;
        #12;
        n_checks++; if (BusyE !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", BusyE); end
        n_checks++; if (DoneE !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", DoneE); end
        n_checks++; if (StallMDE !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", StallMDE); end
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_multu_max();
        int bc;
        logic [31:0] hi, lo;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
        n_checks++; if (bc !== 33) begin n_errors++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
        n_checks++; if (DoneE !== 1'b1) begin n_errors++; $display("FAIL multu_done_pulse got=%b exp=1", DoneE); end
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        n_checks++; if (lo !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        step();
        n_checks++; if (DoneE !== 1'b0) begin n_errors++; $display("FAIL multu_done_width got=%b exp=0", DoneE); end
    endtask

    task automatic test_mult_small();
        int bc;
        logic [31:0] hi, lo, exp_hi;
        run_op(MD_MULTU, 32'd3, 32'd5, bc);
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'h0 || lo !== 32'd15) begin n_errors++; $display("FAIL multu_3x5 got=%h_%h exp=00000000_0000000f", hi, lo); end
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, bc);
        read_hilo(hi, lo);
`ifdef MDU_SIGNED_EN
        exp_hi = 32'hFFFF_FFFF;
`else
        exp_hi = 32'h0000_0002;
`endif
        n_checks++; if (hi !== exp_hi || lo !== 32'hFFFF_FFFA) begin n_errors++; $display("FAIL mult_neg2x3 got=%h_%h exp=%h_fffffffa", hi, lo, exp_hi); end
    endtask

    task automatic test_div();
        int bc;
        logic [31:0] hi, lo, exp_hi, exp_lo;
        run_op(MD_DIVU, 32'd100, 32'd7, bc);
        n_checks++; if (bc !== 33) begin n_errors++; $display("FAIL divu_busy_cycles got=%0d exp=33", bc); end
        read_hilo(hi, lo);
        n_checks++; if (lo !== 32'd14) begin n_errors++; $display("FAIL divu_quot got=%h exp=0000000e", lo); end
        n_checks++; if (hi !== 32'd2) begin n_errors++; $display("FAIL divu_rem got=%h exp=00000002", hi); end
        run_op(MD_DIV, 32'hFFFF_FF9C, 32'd7, bc);
        read_hilo(hi, lo);
`ifdef MDU_SIGNED_EN
        exp_lo = 32'hFFFF_FFF2; exp_hi = 32'hFFFF_FFFE;
`else
        exp_lo = 32'h2492_4916; exp_hi = 32'h0000_0002;
`endif
        n_checks++; if (lo !== exp_lo) begin n_errors++; $display("FAIL div_m100_quot got=%h exp=%h", lo, exp_lo); end
        n_checks++; if (hi !== exp_hi) begin n_errors++; $display("FAIL div_m100_rem got=%h exp=%h", hi, exp_hi); end
    endtask

    task automatic test_div_zero();
        int bc;
        logic [31:0] hi, lo;
        run_op(MD_DIVU, 32'h0000_1234, 32'h0, bc);
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'h0000_1234) begin n_errors++; $display("FAIL div0_hi got=%h exp=00001234", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
    endtask

    task automatic test_mf_stall();
        int busy_n, bad;
        // LO holds 0xFFFFFFFF from the divide-by-zero test
        StartE = 1'b1; MdOpE = MD_MULTU; data1E = 32'h0001_2345; data2E = 32'h0000_0010;
        step();
        StartE = 1'b0; data1E = 32'h0; data2E = 32'h0;
        repeat (4) step();
        MfLoE = 1'b1;
        #1;
        n_checks++; if (StallMDE !== 1'b1) begin n_errors++; $display("FAIL mflo_stall got=%b exp=1", StallMDE); end
        n_checks++; if (MdReadE !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mflo_old_lo got=%h exp=ffffffff", MdReadE); end
        busy_n = 0; bad = 0;
        while (BusyE === 1'b1 && busy_n < 100) begin
            if (StallMDE !== 1'b1) bad++;
            busy_n++;
            step();
        end
        n_checks++; if (busy_n !== 29) begin n_errors++; $display("FAIL mflo_stall_cycles got=%0d exp=29", busy_n); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL mflo_stall_gaps got=%0d exp=0", bad); end
        n_checks++; if (StallMDE !== 1'b0) begin n_errors++; $display("FAIL mflo_stall_release got=%b exp=0", StallMDE); end
        n_checks++; if (MdReadE !== 32'h0012_3450) begin n_errors++; $display("FAIL mflo_new_lo got=%h exp=00123450", MdReadE); end
        MfLoE = 1'b0;
    endtask

    task automatic test_mt();
        int n;
        logic [31:0] hi, lo;
        StartE = 1'b1; MdOpE = MD_MULTU; data1E = 32'd2; data2E = 32'd3;
        step();
        StartE = 1'b0; data1E = 32'h0; data2E = 32'h0;
        repeat (3) step();
        MtHiE = 1'b1; data1E = 32'h0000_DEAD;
        #1;
        n_checks++; if (StallMDE !== 1'b1) begin n_errors++; $display("FAIL mthi_busy_stall got=%b exp=1", StallMDE); end
        step();
        MtHiE = 1'b0; data1E = 32'h0;
        n = 0;
        while (BusyE === 1'b1 && n < 100) begin n++; step(); end
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'h0 || lo !== 32'd6) begin n_errors++; $display("FAIL mthi_busy_dropped got=%h_%h exp=00000000_00000006", hi, lo); end
        MtHiE = 1'b1; data1E = 32'h0000_DEAD;
        step();
        MtHiE = 1'b0; data1E = 32'h0;
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'h0000_DEAD || lo !== 32'd6) begin n_errors++; $display("FAIL mthi_idle got=%h_%h exp=0000dead_00000006", hi, lo); end
        MtLoE = 1'b1; data1E = 32'h0000_BEEF;
        step();
        MtLoE = 1'b0; data1E = 32'h0;
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'h0000_DEAD || lo !== 32'h0000_BEEF) begin n_errors++; $display("FAIL mtlo_idle got=%h_%h exp=0000dead_0000beef", hi, lo); end
    endtask

    task automatic test_reset_mid_op();
        int bc;
        logic [31:0] hi, lo;
        StartE = 1'b1; MdOpE = MD_MULTU; data1E = 32'h0000_FFFF; data2E = 32'h0000_FFFF;
        step();
        StartE = 1'b0; data1E = 32'h0; data2E = 32'h0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        n_checks++; if (BusyE !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got=%b exp=0", BusyE); end
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_errors++; $display("FAIL midrst_hilo got=%h_%h exp=00000000_00000000", hi, lo); end
        rst_n = 1'b1;
        step();
        run_op(MD_DIVU, 32'd100, 32'd7, bc);
        n_checks++; if (bc !== 33) begin n_errors++; $display("FAIL postrst_busy_cycles got=%0d exp=33", bc); end
        read_hilo(hi, lo);
        n_checks++; if (hi !== 32'd2 || lo !== 32'd14) begin n_errors++; $display("FAIL postrst_divu got=%h_%h exp=00000002_0000000e", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_small();
        test_div();
        test_div_zero();
        test_mf_stall();
        test_mt();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
